// File: rtl/csr_pkg.sv
// Shared definitions for the CSR file and trap sequencer: CSR addresses,
// mstatus bit positions, decoder bundle fields, RMW op codes and FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_SEPC     = 12'h141;

  localparam int MSTATUS_SIE  = 1;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_SPIE = 5;
  localparam int MSTATUS_MPIE = 7;

  // Only SIE, MIE, SPIE and MPIE are backed by storage
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_00AA;

  localparam int SIGN_WE   = 5;
  localparam int SIGN_MRET = 4;
  localparam int SIGN_SRET = 3;
  localparam int SIGN_ZIMM = 2;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_SET   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAP_SAVE,
    ST_TRAP_JUMP,
    ST_RET
  } trap_state_e;

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR read-modify-write: produces the new CSR value from the
// old value, the operand and the write/set/clear op.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  input  csr_op_e         op_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = old_i;
    unique case (op_i)
      OP_WRITE: new_o = operand_i;
      OP_SET:   new_o = old_i | operand_i;
      OP_CLEAR: new_o = old_i & ~operand_i;
      // Reserved encoding leaves the register untouched
      default:  new_o = old_i;
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine/supervisor CSR file with exception entry and mret/sret sequencing;
// drives PC redirects and the pipeline stall.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [63:0] RESET_MTVEC = 64'h0,
  parameter int          XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [5:0]      sign_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] zimm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            except_i,
  input  logic [XLEN-1:0] cause_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            illegal_o,
  output logic            busy_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  trap_state_e     state_q, state_d;
  logic            ret_mret_q, ret_mret_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] sepc_q, sepc_d;

  logic            idle;
  logic            is_ret;
  logic            csr_hit;
  logic            rmw_en;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;

  assign idle    = (state_q == ST_IDLE);
  assign is_ret  = sign_i[SIGN_MRET] | sign_i[SIGN_SRET];
  assign operand = sign_i[SIGN_ZIMM] ? zimm_i : rs1_data_i;

  always_comb begin
    old_val = '0;
    csr_hit = 1'b1;
    unique case (csr_addr_i)
      CSR_MSTATUS:  old_val = mstatus_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_SEPC:     old_val = sepc_q;
      default:      csr_hit = 1'b0;
    endcase
  end

  csr_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .old_i     (old_val),
    .operand_i (operand),
    .op_i      (csr_op_e'(sign_i[1:0])),
    .new_o     (new_val)
  );

  // An exception in the same cycle suppresses the CSR op; returns take priority over writes
  assign rmw_en = idle & valid_i & sign_i[SIGN_WE] & ~except_i & ~is_ret & csr_hit;

  assign illegal_o   = ~rst & idle & valid_i & sign_i[SIGN_WE] & ~except_i & ~is_ret & ~csr_hit;
  assign csr_rdata_o = (~rst & idle & valid_i & ~except_i & csr_hit) ? old_val : '0;

  always_comb begin
    state_d       = state_q;
    ret_mret_d    = ret_mret_q;
    mstatus_d     = mstatus_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    sepc_d        = sepc_q;
    busy_o        = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (except_i) begin
          state_d = ST_TRAP_SAVE;
        end else if (valid_i && is_ret) begin
          state_d    = ST_RET;
          ret_mret_d = sign_i[SIGN_MRET];
        end else if (rmw_en) begin
          unique case (csr_addr_i)
            CSR_MSTATUS:  mstatus_d  = new_val & MSTATUS_WMASK;
            CSR_MTVEC:    mtvec_d    = new_val;
            CSR_MSCRATCH: mscratch_d = new_val;
            CSR_MEPC:     mepc_d     = new_val;
            CSR_MCAUSE:   mcause_d   = new_val;
            CSR_SEPC:     sepc_d     = new_val;
            default:      ;
          endcase
        end
      end

      ST_TRAP_SAVE: begin
        busy_o   = 1'b1;
        mepc_d   = pc_i & ALIGN_MASK;
        mcause_d = cause_i;
        state_d  = ST_TRAP_JUMP;
      end

      ST_TRAP_JUMP: begin
        busy_o                  = 1'b1;
        redirect_o              = 1'b1;
        redirect_pc_o           = mtvec_q & ALIGN_MASK;
        mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
        mstatus_d[MSTATUS_MIE]  = 1'b0;
        state_d                 = ST_IDLE;
      end

      ST_RET: begin
        busy_o     = 1'b1;
        redirect_o = 1'b1;
        if (ret_mret_q) begin
          redirect_pc_o           = mepc_q;
          mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
          mstatus_d[MSTATUS_MPIE] = 1'b1;
        end else begin
          redirect_pc_o           = sepc_q;
          mstatus_d[MSTATUS_SIE]  = mstatus_q[MSTATUS_SPIE];
          mstatus_d[MSTATUS_SPIE] = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ret_mret_q <= 1'b0;
      mstatus_q  <= '0;
      mtvec_q    <= RESET_MTVEC[XLEN-1:0];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      sepc_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_mret_q <= ret_mret_d;
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      sepc_q     <= sepc_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: CSR RMW, trap entry, mret/sret, illegal
// access and reset abort, with hand-computed expectations.
module tb_csr_trap_ctrl;

  localparam logic [63:0] RMTVEC = 64'h0000_0000_0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [5:0]  sign_i;
  logic [11:0] csr_addr_i;
  logic [63:0] rs1_data_i;
  logic [63:0] zimm_i;
  logic [63:0] pc_i;
  logic        except_i;
  logic [63:0] cause_i;
  logic [63:0] csr_rdata_o;
  logic        illegal_o;
  logic        busy_o;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(
    .RESET_MTVEC (RMTVEC),
    .XLEN        (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .sign_i        (sign_i),
    .csr_addr_i    (csr_addr_i),
    .rs1_data_i    (rs1_data_i),
    .zimm_i        (zimm_i),
    .pc_i          (pc_i),
    .except_i      (except_i),
    .cause_i       (cause_i),
    .csr_rdata_o   (csr_rdata_o),
    .illegal_o     (illegal_o),
    .busy_o        (busy_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("[%0t] check %s obs=%h exp=%h", $time, tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction slot: drive on the falling edge, settle, then check
  task automatic cyc(input logic v, input logic [5:0] s, input logic [11:0] a,
                     input logic [63:0] r1, input logic [63:0] z);
    @(negedge clk);
    valid_i    = v;
    sign_i     = s;
    csr_addr_i = a;
    rs1_data_i = r1;
    zimm_i     = z;
    #1;
  endtask

  // csrrs with zimm 0: pure read, no state change
  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    cyc(1'b1, 6'b100101, a, 64'h0, 64'h0);
    chk(tag, csr_rdata_o, exp);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; sign_i = '0; csr_addr_i = '0; rs1_data_i = '0;
    zimm_i = '0; pc_i = '0; except_i = 1'b0; cause_i = '0;

    @(negedge clk); #1;
    chk("rst_busy", {63'h0, busy_o}, 64'h0);
    chk("rst_redirect", {63'h0, redirect_o}, 64'h0);
    chk("rst_redirect_pc", redirect_pc_o, 64'h0);
    chk("rst_illegal", {63'h0, illegal_o}, 64'h0);
    @(negedge clk); rst = 1'b0;

    rd(12'h305, RMTVEC, "rst_mtvec");
    rd(12'h300, 64'h0, "rst_mstatus");

    cyc(1'b1, 6'b100000, 12'h340, 64'hDEAD_BEEF, 64'h0);
    chk("csrrw_mscratch_old", csr_rdata_o, 64'h0);
    rd(12'h340, 64'hDEAD_BEEF, "rd_mscratch");

    cyc(1'b1, 6'b100000, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    chk("csrrw_mstatus_old", csr_rdata_o, 64'h0);
    rd(12'h300, 64'hAA, "mstatus_wmask");
    cyc(1'b1, 6'b100100, 12'h300, 64'h0, 64'h8);
    chk("csrrwi_mstatus_old", csr_rdata_o, 64'hAA);
    rd(12'h300, 64'h8, "mstatus_mie");

    cyc(1'b1, 6'b100000, 12'h305, 64'h8000_0103, 64'h0);
    chk("csrrw_mtvec_old", csr_rdata_o, RMTVEC);
    rd(12'h305, 64'h8000_0103, "rd_mtvec");

    // Exception entry
    @(negedge clk);
    valid_i = 1'b0; sign_i = '0; except_i = 1'b1; pc_i = 64'h8000_0044; cause_i = 64'd2;
    #1 chk("trap_c0_busy", {63'h0, busy_o}, 64'h0);
    @(negedge clk); except_i = 1'b0;
    #1 chk("trap_save_busy", {63'h0, busy_o}, 64'h1);
    chk("trap_save_redirect", {63'h0, redirect_o}, 64'h0);
    chk("trap_save_redirect_pc", redirect_pc_o, 64'h0);
    @(negedge clk); #1;
    chk("trap_jump_busy", {63'h0, busy_o}, 64'h1);
    chk("trap_jump_redirect", {63'h0, redirect_o}, 64'h1);
    chk("trap_jump_pc", redirect_pc_o, 64'h8000_0100);
    @(negedge clk); #1;
    chk("trap_done_busy", {63'h0, busy_o}, 64'h0);
    chk("trap_done_redirect", {63'h0, redirect_o}, 64'h0);
    rd(12'h341, 64'h8000_0044, "trap_mepc");
    rd(12'h342, 64'd2, "trap_mcause");
    rd(12'h300, 64'h80, "trap_mstatus");

    // mret
    cyc(1'b1, 6'b010000, 12'h302, 64'h0, 64'h0);
    chk("mret_c0_redirect", {63'h0, redirect_o}, 64'h0);
    cyc(1'b0, 6'b000000, 12'h0, 64'h0, 64'h0);
    chk("mret_busy", {63'h0, busy_o}, 64'h1);
    chk("mret_redirect", {63'h0, redirect_o}, 64'h1);
    chk("mret_pc", redirect_pc_o, 64'h8000_0044);
    cyc(1'b0, 6'b000000, 12'h0, 64'h0, 64'h0);
    chk("mret_after_redirect", {63'h0, redirect_o}, 64'h0);
    chk("mret_after_pc", redirect_pc_o, 64'h0);
    rd(12'h300, 64'h88, "mret_mstatus");

    // sepc write immediately followed by sret
    cyc(1'b1, 6'b100000, 12'h141, 64'h1236, 64'h0);
    chk("csrrw_sepc_old", csr_rdata_o, 64'h0);
    cyc(1'b1, 6'b001000, 12'h102, 64'h0, 64'h0);
    chk("sret_c0_redirect", {63'h0, redirect_o}, 64'h0);
    cyc(1'b0, 6'b000000, 12'h0, 64'h0, 64'h0);
    chk("sret_redirect", {63'h0, redirect_o}, 64'h1);
    chk("sret_pc", redirect_pc_o, 64'h1236);
    cyc(1'b0, 6'b000000, 12'h0, 64'h0, 64'h0);
    chk("sret_after_redirect", {63'h0, redirect_o}, 64'h0);
    rd(12'h300, 64'hA8, "sret_mstatus");

    // Exception and csrrw in the same cycle
    @(negedge clk);
    valid_i = 1'b1; sign_i = 6'b100000; csr_addr_i = 12'h340; rs1_data_i = 64'h55;
    except_i = 1'b1; pc_i = 64'h0000_0200; cause_i = 64'd5;
    #1 chk("combo_illegal", {63'h0, illegal_o}, 64'h0);
    @(negedge clk); except_i = 1'b0; valid_i = 1'b0;
    #1 chk("combo_save_busy", {63'h0, busy_o}, 64'h1);
    @(negedge clk); #1;
    chk("combo_jump_redirect", {63'h0, redirect_o}, 64'h1);
    chk("combo_jump_pc", redirect_pc_o, 64'h8000_0100);
    @(negedge clk); #1;
    chk("combo_done_busy", {63'h0, busy_o}, 64'h0);
    rd(12'h340, 64'hDEAD_BEEF, "combo_mscratch");
    rd(12'h341, 64'h200, "combo_mepc");
    rd(12'h342, 64'd5, "combo_mcause");
    rd(12'h300, 64'hA0, "combo_mstatus");

    // Unimplemented CSR
    cyc(1'b1, 6'b100010, 12'h7C0, 64'hFF, 64'h0);
    chk("illegal_flag", {63'h0, illegal_o}, 64'h1);
    chk("illegal_rdata", csr_rdata_o, 64'h0);
    cyc(1'b0, 6'b000000, 12'h0, 64'h0, 64'h0);
    chk("illegal_clear", {63'h0, illegal_o}, 64'h0);

    // Reset during TRAP_JUMP
    @(negedge clk); except_i = 1'b1; pc_i = 64'h300; cause_i = 64'd7;
    @(negedge clk); except_i = 1'b0;
    #1 chk("abort_save_busy", {63'h0, busy_o}, 64'h1);
    @(negedge clk); #1;
    chk("abort_jump_redirect", {63'h0, redirect_o}, 64'h1);
    rst = 1'b1;
    #1;
    chk("abort_redirect", {63'h0, redirect_o}, 64'h0);
    chk("abort_redirect_pc", redirect_pc_o, 64'h0);
    chk("abort_busy", {63'h0, busy_o}, 64'h0);
    @(negedge clk); #1;
    chk("abort_hold_redirect", {63'h0, redirect_o}, 64'h0);
    rst = 1'b0;
    rd(12'h305, RMTVEC, "abort_mtvec");
    rd(12'h300, 64'h0, "abort_mstatus");
    rd(12'h341, 64'h0, "abort_mepc");
    rd(12'h340, 64'h0, "abort_mscratch");
    rd(12'h342, 64'h0, "abort_mcause");
    cyc(1'b0, 6'b000000, 12'h0, 64'h0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
